// File: rtl/spi_regfile_peripheral_if.sv
// rtl/spi_regfile_peripheral_if.sv - SPI pin bundle between a controller and the register-file peripheral
`timescale 1ns/1ps
interface spi_regfile_peripheral_if;
  logic sclk;
  logic ncs;
  logic copi;
  logic cipo;
  logic cipo_oe;

  modport master (output sclk, output ncs, output copi, input cipo, input cipo_oe);
  modport slave  (input sclk, input ncs, input copi, output cipo, output cipo_oe);
endinterface

// File: rtl/spi_regfile_peripheral.sv
// rtl/spi_regfile_peripheral.sv - SPI slave register file, all four modes, burst read/write with auto-increment
`timescale 1ns/1ps
module spi_regfile_peripheral #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8,
  parameter int CPOL     = 0,
  parameter int CPHA     = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  spi_regfile_peripheral_if.slave    spi,
  output logic [NUM_REGS*DATA_W-1:0] regs,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       ovr_err
);

  localparam int CNT_MAX = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]  CMD_LAST  = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [ADDR_W:0]   REG_LIMIT = (ADDR_W + 1)'(NUM_REGS);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_WDATA, S_RDATA, S_HOLD} state_t;

  // Synchronisers are deliberately unreset so ncs is already valid when reset releases.
  logic [1:0] sclk_sync, ncs_sync, copi_sync;
  logic       sclk_d, ncs_d;

  always_ff @(posedge clk) begin
    sclk_sync <= {sclk_sync[0], spi.sclk};
    ncs_sync  <= {ncs_sync[0], spi.ncs};
    copi_sync <= {copi_sync[0], spi.copi};
    sclk_d    <= sclk_sync[1];
    ncs_d     <= ncs_sync[1];
  end

  logic sclk_s, ncs_s, copi_s;
  logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge;

  assign sclk_s      = sclk_sync[1];
  assign ncs_s       = ncs_sync[1];
  assign copi_s      = copi_sync[1];
  assign sclk_rise   = sclk_s & ~sclk_d;
  assign sclk_fall   = ~sclk_s & sclk_d;
  assign lead_edge   = (CPOL == 0) ? sclk_rise : sclk_fall;
  assign trail_edge  = (CPOL == 0) ? sclk_fall : sclk_rise;
  assign sample_edge = (CPHA == 0) ? lead_edge : trail_edge;
  assign shift_edge  = (CPHA == 0) ? trail_edge : lead_edge;

  state_t              state;
  logic [CNT_W-1:0]    bit_cnt;
  logic [ADDR_W-1:0]   cmd_sr;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-2:0]   wsr;
  logic [DATA_W-1:0]   osr;
  logic                cipo_q, cipo_oe_q;
  logic [DATA_W-1:0]   regs_mem [NUM_REGS];

  logic [ADDR_W:0]     cmd_next;
  logic [DATA_W-1:0]   data_next;
  logic [ADDR_W-1:0]   addr_inc;

  assign cmd_next  = {cmd_sr, copi_s};
  assign data_next = {wsr, copi_s};
  assign addr_inc  = addr + 1'b1;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < REG_LIMIT;
  endfunction

  // Unimplemented addresses match no entry and read as zero.
  function automatic logic [DATA_W-1:0] read_reg(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (a == i[ADDR_W-1:0]) v = regs_mem[i];
    end
    return v;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      cmd_sr    <= '0;
      addr      <= '0;
      wsr       <= '0;
      osr       <= '0;
      cipo_q    <= 1'b0;
      cipo_oe_q <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      ovr_err   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_mem[i] <= '0;
    end else begin
      wr_strobe <= 1'b0;
      // ncs high overrides any coincident SCLK edge, so a racing last bit never commits.
      if (ncs_s) begin
        state     <= S_IDLE;
        cipo_q    <= 1'b0;
        cipo_oe_q <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            bit_cnt <= '0;
            state   <= ncs_d ? S_CMD : S_HOLD;
          end
          S_CMD: begin
            if (sample_edge) begin
              cmd_sr  <= cmd_next[ADDR_W-1:0];
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == CMD_LAST) begin
                bit_cnt <= '0;
                addr    <= cmd_next[ADDR_W-1:0];
                if (cmd_next[ADDR_W]) begin
                  state <= S_WDATA;
                end else begin
                  state     <= S_RDATA;
                  cipo_oe_q <= 1'b1;
                  osr       <= read_reg(cmd_next[ADDR_W-1:0]);
                  if (!in_range(cmd_next[ADDR_W-1:0])) ovr_err <= 1'b1;
                end
              end
            end
          end
          S_WDATA: begin
            if (sample_edge) begin
              wsr     <= data_next[DATA_W-2:0];
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == DATA_LAST) begin
                bit_cnt <= '0;
                addr    <= addr_inc;
                if (in_range(addr)) begin
                  for (int i = 0; i < NUM_REGS; i++) begin
                    if (addr == i[ADDR_W-1:0]) regs_mem[i] <= data_next;
                  end
                  wr_strobe <= 1'b1;
                  wr_addr   <= addr;
                end else begin
                  ovr_err <= 1'b1;
                end
              end
            end
          end
          S_RDATA: begin
            if (shift_edge) begin
              cipo_q <= osr[DATA_W-1];
              osr    <= {osr[DATA_W-2:0], 1'b0};
            end
            if (sample_edge) begin
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == DATA_LAST) begin
                bit_cnt <= '0;
                addr    <= addr_inc;
                osr     <= read_reg(addr_inc);
                if (!in_range(addr_inc)) ovr_err <= 1'b1;
              end
            end
          end
          S_HOLD: begin
            cipo_oe_q <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs[g*DATA_W +: DATA_W] = regs_mem[g];
  end

  assign spi.cipo    = cipo_q;
  assign spi.cipo_oe = cipo_oe_q;

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// tb/tb_spi_regfile_peripheral.sv - randomized self-checking bench driving one peripheral per SPI mode
`timescale 1ns/1ps
module tb_spi_regfile_peripheral;
  localparam int ADDR_W   = 7;
  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 8;
  localparam int HALF     = 60;
  localparam int ASPACE   = 1 << ADDR_W;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [3:0] sclk_v = 4'b1100;
  logic [3:0] ncs_v  = 4'b1111;
  logic [3:0] copi_v = 4'b0000;
  logic [3:0] cipo_v, oe_v, strobe_v, ovr_v;
  logic [NUM_REGS*DATA_W-1:0] regs_v [4];
  logic [ADDR_W-1:0]          wa_v [4];

  for (genvar g = 0; g < 4; g++) begin : g_mode
    spi_regfile_peripheral_if bus ();
    assign bus.sclk    = sclk_v[g];
    assign bus.ncs     = ncs_v[g];
    assign bus.copi    = copi_v[g];
    assign cipo_v[g]   = bus.cipo;
    assign oe_v[g]     = bus.cipo_oe;

    spi_regfile_peripheral #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS),
      .CPOL(g / 2), .CPHA(g % 2)
    ) dut (
      .clk(clk), .reset(reset), .spi(bus),
      .regs(regs_v[g]), .wr_strobe(strobe_v[g]), .wr_addr(wa_v[g]), .ovr_err(ovr_v[g])
    );
  end

  int n_checks = 0;
  int n_errors = 0;
  int strobe_cnt [4] = '{0, 0, 0, 0};

  always @(negedge clk) begin
    for (int m = 0; m < 4; m++) if (strobe_v[m] === 1'b1) strobe_cnt[m]++;
  end

  // Reference model: what each peripheral's register file should hold
  logic [DATA_W-1:0] mreg [4][NUM_REGS];
  bit                movr [4];
  int                mstb [4];
  int                mwa  [4];

  logic [DATA_W-1:0] wq [$];
  bit                tx_q [$];
  bit                rx_q [$];
  bit                oe_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 4; m++) begin
      for (int i = 0; i < NUM_REGS; i++) mreg[m][i] = '0;
      movr[m] = 1'b0;
      mwa[m]  = 0;
    end
  endtask

  function automatic logic [63:0] model_pack(input int m);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < NUM_REGS; i++) v[i*DATA_W +: DATA_W] = mreg[m][i];
    return v;
  endfunction

  // One frame on mode m; abort_bits >= 0 raises ncs after that many data bits,
  // rst_at >= 0 pulses reset before that bit index with ncs held low.
  task automatic do_frame(input int m, input bit rw, input int addr, input int nwords,
                          input int abort_bits, input int rst_at);
    logic idle_lvl;
    int   nbits, done, oe_bad;
    bit   did_reset;
    idle_lvl  = (m >= 2);
    did_reset = 0;
    tx_q.delete(); rx_q.delete(); oe_q.delete();
    tx_q.push_back(rw);
    for (int b = ADDR_W - 1; b >= 0; b--) tx_q.push_back(addr[b]);
    for (int k = 0; k < nwords; k++)
      for (int b = DATA_W - 1; b >= 0; b--) tx_q.push_back(wq[k][b]);
    nbits = (abort_bits >= 0) ? 1 + ADDR_W + abort_bits : tx_q.size();

    ncs_v[m] = 1'b0;
    #100;
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        reset = 1'b1;
        #30;
        reset = 1'b0;
        model_reset();
        did_reset = 1;
      end
      if (m % 2 == 0) begin
        copi_v[m] = tx_q[i];
        #HALF;
        rx_q.push_back(cipo_v[m]); oe_q.push_back(oe_v[m]);
        sclk_v[m] = ~idle_lvl;
        #HALF;
        sclk_v[m] = idle_lvl;
      end else begin
        sclk_v[m] = ~idle_lvl;
        copi_v[m] = tx_q[i];
        #HALF;
        rx_q.push_back(cipo_v[m]); oe_q.push_back(oe_v[m]);
        sclk_v[m] = idle_lvl;
        #HALF;
      end
    end
    #HALF;
    ncs_v[m] = 1'b1;
    #200;

    done = (abort_bits >= 0) ? abort_bits / DATA_W : nwords;
    if (did_reset) done = 0;
    oe_bad = 0;
    for (int i = 0; i < nbits; i++) begin
      bit exp_oe;
      exp_oe = !did_reset && !rw && (i >= 1 + ADDR_W);
      if (oe_q[i] != exp_oe) oe_bad++;
    end
    for (int k = 0; k < done; k++) begin
      int a;
      a = (addr + k) % ASPACE;
      if (rw) begin
        if (a < NUM_REGS) begin
          mreg[m][a] = wq[k];
          mstb[m]++;
          mwa[m] = a;
        end else begin
          movr[m] = 1'b1;
        end
      end else begin
        logic [DATA_W-1:0] got, exp;
        got = '0;
        for (int j = 0; j < DATA_W; j++) got = {got[DATA_W-2:0], rx_q[1 + ADDR_W + k*DATA_W + j]};
        exp = (a < NUM_REGS) ? mreg[m][a] : '0;
        if (a >= NUM_REGS) movr[m] = 1'b1;
        if ((a + 1) % ASPACE >= NUM_REGS) movr[m] = 1'b1;
        check($sformatf("rd_word m%0d a%0d", m, a), 64'(got), 64'(exp));
      end
    end
    check($sformatf("cipo_oe m%0d", m), 64'(oe_bad), 64'd0);
    check($sformatf("regs m%0d", m), regs_v[m], model_pack(m));
    check($sformatf("strobes m%0d", m), 64'(strobe_cnt[m]), 64'(mstb[m]));
    check($sformatf("ovr m%0d", m), 64'(ovr_v[m]), 64'(movr[m]));
    check($sformatf("wr_addr m%0d", m), 64'(wa_v[m]), 64'(mwa[m]));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int m, pick, addr, n;
    bit rw;
    for (int i = 0; i < 4; i++) mstb[i] = 0;
    model_reset();
    reset = 1'b1;
    #100;
    reset = 1'b0;
    #100;
    for (int i = 0; i < 4; i++) begin
      check("rst regs", regs_v[i], 64'd0);
      check("rst cipo_oe", 64'(oe_v[i]), 64'd0);
      check("rst cipo", 64'(cipo_v[i]), 64'd0);
      check("rst ovr", 64'(ovr_v[i]), 64'd0);
      check("rst wr_addr", 64'(wa_v[i]), 64'd0);
      check("rst strobe", 64'(strobe_v[i]), 64'd0);
    end

    wq.delete(); wq.push_back(8'h0A);
    do_frame(0, 1, 3, 1, -1, -1);
    check("m0 reg3", 64'(regs_v[0][3*DATA_W +: DATA_W]), 64'h0A);

    for (int i = 1; i < 4; i++) begin
      wq.delete(); wq.push_back(8'h5C);
      do_frame(i, 1, 1, 1, -1, -1);
      wq.delete(); wq.push_back(8'h00);
      do_frame(i, 0, 1, 1, -1, -1);
    end

    wq.delete(); wq.push_back(8'h11); wq.push_back(8'h22); wq.push_back(8'h33);
    do_frame(0, 1, 6, 3, -1, -1);

    wq.delete(); wq.push_back(8'h00); wq.push_back(8'h00);
    do_frame(0, 0, 7'h7F, 2, -1, -1);

    wq.delete(); wq.push_back(8'hA5);
    do_frame(1, 1, 2, 1, 4, -1);
    wq.delete(); wq.push_back(8'h3C);
    do_frame(1, 1, 2, 1, -1, -1);

    for (int t = 0; t < 24; t++) begin
      m    = $urandom_range(0, 3);
      rw   = 1'($urandom_range(0, 1));
      pick = $urandom_range(0, 3);
      case (pick)
        0:       addr = $urandom_range(0, NUM_REGS - 1);
        1:       addr = $urandom_range(0, ASPACE - 1);
        2:       addr = ASPACE - 2 + $urandom_range(0, 1);
        default: addr = NUM_REGS - 3 + $urandom_range(0, 4);
      endcase
      n = $urandom_range(1, 3);
      wq.delete();
      for (int k = 0; k < n; k++) wq.push_back(8'($urandom));
      do_frame(m, rw, addr, n, -1, -1);
    end

    wq.delete(); wq.push_back(8'h77);
    do_frame(2, 1, 4, 1, -1, 12);
    for (int i = 0; i < 4; i++) begin
      check("post-reset regs", regs_v[i], 64'd0);
      check("post-reset ovr", 64'(ovr_v[i]), 64'd0);
    end
    wq.delete(); wq.push_back(8'h99);
    do_frame(2, 1, 4, 1, -1, -1);
    check("m2 reg4", 64'(regs_v[2][4*DATA_W +: DATA_W]), 64'h99);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
